// File: rtl/gsensor_pkg.sv
// Shared constants, types and helpers for the G-sensor SPI responder.
// Optional feature macro: GSENSOR_RESP_SELFTEST_EN (self-test offsets at capture).
package gsensor_pkg;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DEVID       = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [ADDR_W-1:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [ADDR_W-1:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
  localparam logic [ADDR_W-1:0] ADDR_DATAX1      = 6'h33;
  localparam logic [ADDR_W-1:0] ADDR_DATAY0      = 6'h34;
  localparam logic [ADDR_W-1:0] ADDR_DATAY1      = 6'h35;
  localparam logic [ADDR_W-1:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [DATA_W-1:0] POWER_CTL_RST   = 8'h00;
  localparam logic [DATA_W-1:0] INT_ENABLE_RST  = 8'h00;
  localparam logic [DATA_W-1:0] DATA_FORMAT_RST = 8'h00;

  localparam int unsigned MEASURE_BIT    = 3;
  localparam int unsigned INT_DR_BIT     = 7;
  localparam int unsigned SELF_TEST_BIT  = 7;

  localparam logic [SAMPLE_W-1:0] SELFTEST_OFF_XY = 16'h0040;
  localparam logic [SAMPLE_W-1:0] SELFTEST_OFF_Z  = 16'hFFC0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

  // True for the six sample data registers
  function automatic logic is_data_addr(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

  // True for registers the initiator may write
  function automatic logic is_writable(input logic [ADDR_W-1:0] a);
    return (a == ADDR_BW_RATE) || (a == ADDR_POWER_CTL) ||
           (a == ADDR_INT_ENABLE) || (a == ADDR_DATA_FORMAT);
  endfunction

endpackage

// File: rtl/gsensor_regfile.sv
// Register storage, sample capture/pending commit, DATA_READY and int1.
// GSENSOR_RESP_SELFTEST_EN: DATA_FORMAT[7] offsets captured samples.
module gsensor_regfile
  import gsensor_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                csn_s,
  input  logic                csn_rise,
  input  logic                rd_clr,
  input  logic                wr_en,
  input  reg_wr_t             wr_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data_c,
  input  logic [SAMPLE_W-1:0] sample_x,
  input  logic [SAMPLE_W-1:0] sample_y,
  input  logic [SAMPLE_W-1:0] sample_z,
  input  logic                sample_valid,
  output logic                int1,
  output logic                reg_wr_stb,
  output logic [ADDR_W-1:0]   reg_wr_addr,
  output logic [DATA_W-1:0]   reg_wr_data
);

  logic [DATA_W-1:0]   bw_rate_q, bw_rate_d;
  logic [DATA_W-1:0]   power_ctl_q, power_ctl_d;
  logic [DATA_W-1:0]   int_enable_q, int_enable_d;
  logic [DATA_W-1:0]   data_format_q, data_format_d;
  logic [SAMPLE_W-1:0] dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic [SAMPLE_W-1:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic                pend_q, pend_d;
  logic                data_ready_q, data_ready_d;
  logic                int1_q, int1_d;
  logic                stb_q, stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                st_on;
  logic [SAMPLE_W-1:0] cap_x, cap_y, cap_z;

`ifdef GSENSOR_RESP_SELFTEST_EN
  assign st_on = data_format_q[SELF_TEST_BIT];
`else
  assign st_on = 1'b0;
`endif

  // Self-test adjusted capture values (16-bit wrap-around)
  always_comb begin
    cap_x = sample_x + (st_on ? SELFTEST_OFF_XY : 16'h0000);
    cap_y = sample_y + (st_on ? SELFTEST_OFF_XY : 16'h0000);
    cap_z = sample_z + (st_on ? SELFTEST_OFF_Z  : 16'h0000);
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_data_c = '0;
    case (rd_addr)
      ADDR_DEVID:       rd_data_c = DEVID;
      ADDR_BW_RATE:     rd_data_c = bw_rate_q;
      ADDR_POWER_CTL:   rd_data_c = power_ctl_q;
      ADDR_INT_ENABLE:  rd_data_c = int_enable_q;
      ADDR_INT_SOURCE:  rd_data_c = {data_ready_q, 7'b0};
      ADDR_DATA_FORMAT: rd_data_c = data_format_q;
      ADDR_DATAX0:      rd_data_c = dx_q[7:0];
      ADDR_DATAX1:      rd_data_c = dx_q[15:8];
      ADDR_DATAY0:      rd_data_c = dy_q[7:0];
      ADDR_DATAY1:      rd_data_c = dy_q[15:8];
      ADDR_DATAZ0:      rd_data_c = dz_q[7:0];
      ADDR_DATAZ1:      rd_data_c = dz_q[15:8];
      default:          rd_data_c = '0;
    endcase
  end

  // Next-state: register writes, sample commit, DATA_READY, interrupt
  always_comb begin
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_enable_d  = int_enable_q;
    data_format_d = data_format_q;
    dx_d = dx_q; dy_d = dy_q; dz_d = dz_q;
    px_d = px_q; py_d = py_q; pz_d = pz_q;
    pend_d        = pend_q;
    data_ready_d  = data_ready_q;
    stb_d         = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;

    if (wr_en && is_writable(wr_req.addr)) begin
      stb_d     = 1'b1;
      wr_addr_d = wr_req.addr;
      wr_data_d = wr_req.data;
      case (wr_req.addr)
        ADDR_BW_RATE:     bw_rate_d     = wr_req.data;
        ADDR_POWER_CTL:   power_ctl_d   = wr_req.data;
        ADDR_INT_ENABLE:  int_enable_d  = wr_req.data;
        ADDR_DATA_FORMAT: data_format_d = wr_req.data;
        default:          ;
      endcase
    end

    // Commit takes priority over a read clear on the same CSN rise
    if (csn_rise && pend_q) begin
      dx_d = px_q; dy_d = py_q; dz_d = pz_q;
      pend_d       = 1'b0;
      data_ready_d = 1'b1;
    end else if (rd_clr) begin
      data_ready_d = 1'b0;
    end

    if (sample_valid && power_ctl_q[MEASURE_BIT]) begin
      if (csn_s) begin
        dx_d = cap_x; dy_d = cap_y; dz_d = cap_z;
        data_ready_d = 1'b1;
      end else begin
        px_d = cap_x; py_d = cap_y; pz_d = cap_z;
        pend_d = 1'b1;
      end
    end

    int1_d = data_ready_d & int_enable_d[INT_DR_BIT];
  end

  // Register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bw_rate_q     <= BW_RATE_RST;
      power_ctl_q   <= POWER_CTL_RST;
      int_enable_q  <= INT_ENABLE_RST;
      data_format_q <= DATA_FORMAT_RST;
      dx_q <= '0; dy_q <= '0; dz_q <= '0;
      px_q <= '0; py_q <= '0; pz_q <= '0;
      pend_q        <= 1'b0;
      data_ready_q  <= 1'b0;
      int1_q        <= 1'b0;
      stb_q         <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_enable_q  <= int_enable_d;
      data_format_q <= data_format_d;
      dx_q <= dx_d; dy_q <= dy_d; dz_q <= dz_d;
      px_q <= px_d; py_q <= py_d; pz_q <= pz_d;
      pend_q        <= pend_d;
      data_ready_q  <= data_ready_d;
      int1_q        <= int1_d;
      stb_q         <= stb_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign int1        = int1_q;
  assign reg_wr_stb  = stb_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 responder emulating the accelerometer register subset.
// Optional feature macro: GSENSOR_RESP_SELFTEST_EN (handled in gsensor_regfile).
module gsensor_spi_responder
  import gsensor_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                spi_csn,
  input  logic                spi_sclk,
  input  logic                spi_sdi,
  output logic                spi_sdo,
  output logic                spi_sdo_oe,
  input  logic [SAMPLE_W-1:0] sample_x,
  input  logic [SAMPLE_W-1:0] sample_y,
  input  logic [SAMPLE_W-1:0] sample_z,
  input  logic                sample_valid,
  output logic                int1,
  output logic                reg_wr_stb,
  output logic [ADDR_W-1:0]   reg_wr_addr,
  output logic [DATA_W-1:0]   reg_wr_data
);

  logic [1:0]           csn_sync_q, sclk_sync_q, sdi_sync_q;
  logic                 csn_prev_q, sclk_prev_q;
  logic                 csn_s, sdi_s, sclk_rise, sclk_fall, csn_rise;

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    rx_q, rx_d, tx_q, tx_d, rx_byte;
  logic [ADDR_W-1:0]    addr_q, addr_d, addr_step, rd_addr;
  logic                 mb_q, mb_d, hit_q, hit_d;
  logic                 sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
  logic                 wr_en;
  reg_wr_t              wr_req;
  logic [DATA_W-1:0]    rd_data;

  // Two-flop synchronisers plus edge-history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn_sync_q  <= 2'b11;
      sclk_sync_q <= 2'b11;
      sdi_sync_q  <= 2'b00;
      csn_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      csn_sync_q  <= {csn_sync_q[0], spi_csn};
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
      sdi_sync_q  <= {sdi_sync_q[0], spi_sdi};
      csn_prev_q  <= csn_sync_q[1];
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign csn_s     = csn_sync_q[1];
  assign sdi_s     = sdi_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;

  // Frame FSM next-state, shift registers and address stepping
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    mb_d      = mb_q;
    hit_d     = hit_q;
    sdo_d     = sdo_q;
    wr_en     = 1'b0;
    rx_byte   = {rx_q[6:0], sdi_s};
    addr_step = mb_q ? addr_q + 6'd1 : addr_q;
    rd_addr   = addr_q;
    wr_req    = '{addr: addr_q, data: rx_byte};

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        sdo_d     = 1'b0;
        if (!csn_s) begin
          state_d = ST_CMD;
          hit_d   = 1'b0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d = rx_byte[5:0];
            mb_d   = rx_byte[6];
            if (rx_byte[7]) begin
              rd_addr = rx_byte[5:0];
              tx_d    = rd_data;
              state_d = ST_RD_DATA;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
        end
      end
      ST_WR_DATA: begin
        if (sclk_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_en  = 1'b1;
            addr_d = addr_step;
          end
        end
      end
      ST_RD_DATA: begin
        if (sclk_fall) begin
          sdo_d = tx_q[7];
          tx_d  = {tx_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (is_data_addr(addr_q)) hit_d = 1'b1;
            addr_d  = addr_step;
            rd_addr = addr_step;
            tx_d    = rd_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CSN high ends the frame and drops any partial byte
    if (csn_s) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
    end

    sdo_oe_d = (state_q == ST_RD_DATA) && !csn_s;
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      mb_q      <= 1'b0;
      hit_q     <= 1'b0;
      sdo_q     <= 1'b0;
      sdo_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      mb_q      <= mb_d;
      hit_q     <= hit_d;
      sdo_q     <= sdo_d;
      sdo_oe_q  <= sdo_oe_d;
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = sdo_oe_q;

  gsensor_regfile #(
    .DEVID       (DEVID),
    .BW_RATE_RST (BW_RATE_RST)
  ) u_regfile (
    .clk          (clk),
    .reset_n      (reset_n),
    .csn_s        (csn_s),
    .csn_rise     (csn_rise),
    .rd_clr       (csn_rise & hit_q),
    .wr_en        (wr_en),
    .wr_req       (wr_req),
    .rd_addr      (rd_addr),
    .rd_data_c    (rd_data),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .int1         (int1),
    .reg_wr_stb   (reg_wr_stb),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data)
  );

endmodule
